// File: rtl/vx_mask_accum_pkg.sv
// vx_mask_accum_pkg
//   Shared helpers for the mask accumulator slice.
//   idx_width(w): width of a bit index into a w-bit mask, never below 1 so a
//   1-bit mask still has a real index port (index 1 is then out of range).
package vx_mask_accum_pkg;

    function automatic int idx_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/vx_mask_accum_popcount.sv
// vx_popcount
//   Combinational population count.
//   Ports:
//     in_vec  [N-1:0]      vector to count
//     cnt     [CNT_W-1:0]  number of set bits in in_vec
module vx_popcount #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     in_vec,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CNT_W'(in_vec[i]);
        end
    end

endmodule

// File: rtl/vx_mask_accum.sv
// vx_mask_accum
//   Rebuilds a bit mask from a stream of leading/trailing-zero encoder
//   indices. Each accepted beat ORs one bit into an accumulator; the beat
//   flagged in_last moves the finished mask, its popcount and an error flag
//   into a one-entry output register.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset
//     in_valid/in_ready index beat handshake
//     in_idx            bit index (from LSB when MODE=0, from MSB when MODE=1)
//     in_empty          beat carries no index
//     in_last           final beat of the current mask
//     out_valid/out_ready  output handshake
//     out_mask, out_count, out_err  rebuilt mask, its popcount, bad-index flag
module vx_mask_accum
    import vx_mask_accum_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int MODE  = 0,
    localparam int IDX_W = idx_width(WIDTH),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_empty,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_mask,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    input  logic             out_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] acc;
    logic             err;

    logic [WIDTH-1:0] raw_bit, beat_bit;
    logic             accept, out_hs, beat_vld, in_range, beat_err;
    logic [WIDTH-1:0] load_mask;
    logic             load_err;
    logic [CNT_W-1:0] load_cnt;

    assign in_ready  = (state == EMPTY) | out_ready;
    assign out_valid = (state == FULL);
    assign accept    = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    // Out-of-range indices shift the one-hot past the top and leave no bit;
    // in_range still has to be checked for the error flag.
    assign in_range = {1'b0, in_idx} < LIMIT;
    assign raw_bit  = WIDTH'(1) << in_idx;

    // Leading-zero indices count from the MSB: mirror the one-hot.
    for (genvar i = 0; i < WIDTH; i++) begin : g_map
        if (MODE == 1) begin : g_lead
            assign beat_bit[i] = raw_bit[WIDTH-1-i];
        end else begin : g_trail
            assign beat_bit[i] = raw_bit[i];
        end
    end

    assign beat_vld  = accept & ~in_empty;
    assign beat_err  = beat_vld & (~in_range | (|(acc & beat_bit)));
    assign load_mask = acc | (beat_vld ? beat_bit : '0);
    assign load_err  = err | beat_err;

    // Count the value about to be registered so the output path is flop-only.
    vx_popcount #(.N(WIDTH), .CNT_W(CNT_W)) u_popcount (
        .in_vec (load_mask),
        .cnt    (load_cnt)
    );

    always_comb begin
        state_n = state;
        if (accept && in_last) begin
            state_n = FULL;         // reload wins over a same-cycle drain
        end else if (out_hs) begin
            state_n = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            acc       <= '0;
            err       <= 1'b0;
            out_mask  <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                if (in_last) begin
                    out_mask  <= load_mask;
                    out_count <= load_cnt;
                    out_err   <= load_err;
                    acc       <= '0;
                    err       <= 1'b0;
                end else begin
                    acc <= load_mask;
                    err <= load_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_mask_accum.sv
module tb_vx_mask_accum;

    logic       clk = 1'b0;
    logic       reset;
    logic       v, emp, last, ordy;
    logic [2:0] idx;

    logic       rdy0, rdy1, rdy6, ov0, ov1, ov6, oe0, oe1, oe6;
    logic [7:0] om0, om1;
    logic [5:0] om6;
    logic [3:0] oc0, oc1;
    logic [2:0] oc6;

    logic       v1, i1, e1, l1, or1, r1, ov1w, oe1w;
    logic [0:0] om1w, oc1w;

    always #5 clk = ~clk;

    vx_mask_accum #(.WIDTH(8), .MODE(0)) d0 (
        .clk(clk), .reset(reset), .in_valid(v), .in_idx(idx), .in_empty(emp),
        .in_last(last), .in_ready(rdy0), .out_valid(ov0), .out_mask(om0),
        .out_count(oc0), .out_err(oe0), .out_ready(ordy));
    vx_mask_accum #(.WIDTH(8), .MODE(1)) d1 (
        .clk(clk), .reset(reset), .in_valid(v), .in_idx(idx), .in_empty(emp),
        .in_last(last), .in_ready(rdy1), .out_valid(ov1), .out_mask(om1),
        .out_count(oc1), .out_err(oe1), .out_ready(ordy));
    vx_mask_accum #(.WIDTH(6), .MODE(0)) d6 (
        .clk(clk), .reset(reset), .in_valid(v), .in_idx(idx), .in_empty(emp),
        .in_last(last), .in_ready(rdy6), .out_valid(ov6), .out_mask(om6),
        .out_count(oc6), .out_err(oe6), .out_ready(ordy));
    vx_mask_accum #(.WIDTH(1), .MODE(0)) dw1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_idx(i1), .in_empty(e1),
        .in_last(l1), .in_ready(r1), .out_valid(ov1w), .out_mask(om1w),
        .out_count(oc1w), .out_err(oe1w), .out_ready(or1));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the beats of the mask in flight, rebuilt per config
    // from the index rules when the last beat is taken.
    int         q[$];
    bit         exp_valid;
    logic [7:0] exp_m[3];
    int         exp_c[3];
    bit         exp_e[3];
    int         cw[3] = '{8, 8, 6};
    int         cm[3] = '{0, 1, 0};

    task automatic model_load();
        for (int c = 0; c < 3; c++) begin
            logic [7:0] m = '0;
            bit e = 1'b0;
            foreach (q[k]) begin
                if (q[k] < 0) continue;
                if (q[k] >= cw[c]) e = 1'b1;
                else begin
                    int pos = (cm[c] == 1) ? (cw[c] - 1 - q[k]) : q[k];
                    if (m[pos]) e = 1'b1;
                    m[pos] = 1'b1;
                end
            end
            exp_m[c] = m;
            exp_c[c] = $countones(m);
            exp_e[c] = e;
        end
    endtask

    task automatic cmp_out();
        chk("out_valid_w8m0", ov0, exp_valid);
        chk("out_valid_w8m1", ov1, exp_valid);
        chk("out_valid_w6", ov6, exp_valid);
        if (exp_valid) begin
            chk("mask_w8m0", om0, exp_m[0]);
            chk("mask_w8m1", om1, exp_m[1]);
            chk("mask_w6", om6, exp_m[2][5:0]);
            chk("count_w8m0", oc0, exp_c[0]);
            chk("count_w8m1", oc1, exp_c[1]);
            chk("count_w6", oc6, exp_c[2]);
            chk("err_w8m0", oe0, exp_e[0]);
            chk("err_w8m1", oe1, exp_e[1]);
            chk("err_w6", oe6, exp_e[2]);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit iv, input int ii, input bit ie, input bit il, input bit ir);
        bit erdy, hs;
        v = iv; idx = 3'(ii); emp = ie; last = il; ordy = ir;
        erdy = !exp_valid || ir;
        #1;
        chk("in_ready_w8m0", rdy0, erdy);
        chk("in_ready_w8m1", rdy1, erdy);
        chk("in_ready_w6", rdy6, erdy);
        @(posedge clk);
        hs = exp_valid && ir;
        if (iv && erdy) begin
            q.push_back(ie ? -1 : ii);
            if (il) begin
                model_load();
                q.delete();
            end
        end
        if (iv && erdy && il) exp_valid = 1'b1;
        else if (hs) exp_valid = 1'b0;
        @(negedge clk);
        cmp_out();
    endtask

    task automatic w1(input bit iv, input bit ii, input bit il);
        v1 = iv; i1 = ii; l1 = il;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [3:0]       n;
        logic [7:0][2:0]  idx;
        logic [7:0]       emp;
        logic [7:0]       m0, m1;
        logic [5:0]       m6;
        logic [3:0]       c0, c1;
        logic [2:0]       c6;
        logic [2:0]       e;     // {w6, w8m1, w8m0}
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{n:3, idx:{15'd0, 3'd7, 3'd3, 3'd0}, emp:8'h00, m0:8'h89, m1:8'h91, m6:6'h09, c0:3, c1:3, c6:2, e:3'b100};
        tbl[1] = '{n:2, idx:{18'd0, 3'd6, 3'd0}, emp:8'h00, m0:8'h41, m1:8'h82, m6:6'h01, c0:2, c1:2, c6:1, e:3'b100};
        tbl[2] = '{n:2, idx:{18'd0, 3'd2, 3'd2}, emp:8'h00, m0:8'h04, m1:8'h20, m6:6'h04, c0:1, c1:1, c6:1, e:3'b111};
        tbl[3] = '{n:1, idx:{21'd0, 3'd7}, emp:8'h00, m0:8'h80, m1:8'h01, m6:6'h00, c0:1, c1:1, c6:0, e:3'b100};
        tbl[4] = '{n:1, idx:{21'd0, 3'd5}, emp:8'h01, m0:8'h00, m1:8'h00, m6:6'h00, c0:0, c1:0, c6:0, e:3'b000};
        tbl[5] = '{n:3, idx:{15'd0, 3'd0, 3'd5, 3'd0}, emp:8'h05, m0:8'h20, m1:8'h04, m6:6'h20, c0:1, c1:1, c6:1, e:3'b000};
        tbl[6] = '{n:8, idx:{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, emp:8'h00,
                   m0:8'hFF, m1:8'hFF, m6:6'h3F, c0:8, c1:8, c6:6, e:3'b100};

        reset = 1'b0;
        v = 0; idx = 0; emp = 0; last = 0; ordy = 0;
        v1 = 0; i1 = 0; e1 = 0; l1 = 0; or1 = 1;
        exp_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", ov0, 0);
        chk("rst_mask", om0, 0);
        chk("rst_count", oc0, 0);
        chk("rst_err", oe0, 0);
        chk("rst_w1_valid", ov1w, 0);
        reset = 1'b1;

        // in_ready is checked on the very first cycle after release
        step(0, 0, 0, 0, 0);

        // directed table
        for (int t = 0; t < 7; t++) begin
            for (int b = 0; b < int'(tbl[t].n); b++)
                step(1, int'(tbl[t].idx[b]), tbl[t].emp[b], b == int'(tbl[t].n) - 1, 1);
            chk("tbl_valid", ov0, 1);
            chk("tbl_mask_w8m0", om0, tbl[t].m0);
            chk("tbl_mask_w8m1", om1, tbl[t].m1);
            chk("tbl_mask_w6", om6, tbl[t].m6);
            chk("tbl_count_w8m0", oc0, tbl[t].c0);
            chk("tbl_count_w8m1", oc1, tbl[t].c1);
            chk("tbl_count_w6", oc6, tbl[t].c6);
            chk("tbl_err", {oe6, oe1, oe0}, tbl[t].e);
        end
        step(0, 0, 0, 0, 1);

        // stall in FULL, then drain together with a new last beat
        step(1, 1, 0, 1, 1);
        for (int s = 0; s < 5; s++) begin
            step(1, 3, 0, 0, 0);
            chk("stall_mask", om0, 8'h02);
            chk("stall_ready", rdy0, 0);
        end
        step(1, 4, 0, 1, 1);
        chk("nobubble_valid", ov0, 1);
        chk("nobubble_mask", om0, 8'h10);
        step(0, 0, 0, 0, 1);

        // reset in the middle of a mask
        step(1, 1, 0, 0, 1);
        step(1, 4, 0, 0, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", ov0, 0);
        chk("async_rst_mask", om0, 0);
        chk("async_rst_count", oc0, 0);
        q.delete();
        exp_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1, 5, 0, 1, 1);
        chk("post_rst_mask", om0, 8'h20);
        chk("post_rst_count", oc0, 1);
        step(0, 0, 0, 0, 1);

        // WIDTH=1 instance
        w1(1, 0, 1);
        chk("w1_valid", ov1w, 1);
        chk("w1_mask", om1w, 1);
        chk("w1_count", oc1w, 1);
        chk("w1_err", oe1w, 0);
        w1(1, 1, 1);
        chk("w1_oor_valid", ov1w, 1);
        chk("w1_oor_mask", om1w, 0);
        chk("w1_oor_count", oc1w, 0);
        chk("w1_oor_err", oe1w, 1);
        w1(1, 0, 0);
        w1(1, 0, 1);
        chk("w1_dup_mask", om1w, 1);
        chk("w1_dup_count", oc1w, 1);
        chk("w1_dup_err", oe1w, 1);
        w1(0, 0, 0);
        chk("w1_drain_valid", ov1w, 0);

        // randomized traffic against the model
        for (int r = 0; r < 600; r++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
